// File: rtl/rb_pkg.sv
// rb_pkg: lane types, event bundle and scoring constants shared by the note hit judge.
package rb_pkg;
  localparam int NUM_LANES  = 4;
  localparam int PEND_MAX   = 3;
  localparam int POINTS     = 10;
  localparam int COMBO_STEP = 10;
  localparam int MULT_MAX   = 4;
  localparam int SCORE_W    = 20;
  localparam int CNT_W      = $clog2(PEND_MAX + 1);
  typedef logic [NUM_LANES-1:0] lane_vec_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    lane_vec_t hit;
    lane_vec_t miss;
  } judge_evt_t;
  localparam cnt_t CNT_FULL = cnt_t'(PEND_MAX);
endpackage

// File: rtl/note_hit_judge_if.sv
// note_hit_judge_if: note-register taps and buttons in, judged pulses and score state out.
interface note_hit_judge_if;
  import rb_pkg::*;
  logic               frame_tick;
  logic               playing;
  lane_vec_t          lane_enter;
  lane_vec_t          lane_exit;
  lane_vec_t          buttons;
  lane_vec_t          hit_pulse;
  lane_vec_t          miss_pulse;
  logic [SCORE_W-1:0] score;
  logic [7:0]         combo;
  logic [2:0]         multiplier;
  modport master (
    output frame_tick, playing, lane_enter, lane_exit, buttons,
    input  hit_pulse, miss_pulse, score, combo, multiplier
  );
  modport slave (
    input  frame_tick, playing, lane_enter, lane_exit, buttons,
    output hit_pulse, miss_pulse, score, combo, multiplier
  );
endinterface

// File: rtl/lane_tracker.sv
// lane_tracker: one lane's button synchroniser/edge detect and hit-window pend/done counters.
// GHOST_PENALTY_EN: a press on a lane with nothing pending reports a miss.
module lane_tracker
  import rb_pkg::*;
(
  input  logic Clk,
  input  logic Reset_n,
  input  logic playing,
  input  logic tick,
  input  logic enter_tap,
  input  logic exit_tap,
  input  logic button,
  output logic hit,
  output logic miss
);
  logic s1, s2, s3, armed, press;
  logic [1:0] warm;
  cnt_t pend, done, pend_n, done_n;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      {s1, s2, s3, armed} <= '0;
      warm <= '0;
      pend <= '0;
      done <= '0;
    end else begin
      {s1, s2, s3} <= {button, s1, s2};
      warm <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & ~s2);
      pend <= pend_n;
      done <= done_n;
    end
  // armed waits to see the button released, so a press held through reset never edges
  assign press = s2 & ~s3 & armed;
  always_comb begin
    pend_n = pend;
    done_n = done;
    hit = 1'b0;
    miss = 1'b0;
    if (press && pend_n != '0) begin
      pend_n = pend_n - cnt_t'(1);
      done_n = (done_n == CNT_FULL) ? done_n : done_n + cnt_t'(1);
      hit = 1'b1;
    end
`ifdef GHOST_PENALTY_EN
    else if (press) miss = 1'b1;
`endif
    if (tick && exit_tap) begin
      if (done_n != '0) done_n = done_n - cnt_t'(1);
      else if (pend_n != '0) begin
        pend_n = pend_n - cnt_t'(1);
        miss = 1'b1;
      end
    end
    if (tick && enter_tap && pend_n != CNT_FULL) pend_n = pend_n + cnt_t'(1);
    if (!playing) begin
      pend_n = '0;
      done_n = '0;
      hit = 1'b0;
      miss = 1'b0;
    end
  end
endmodule

// File: rtl/note_hit_judge.sv
// note_hit_judge: per-lane hit/miss judging plus score, combo and multiplier for the display.
// GHOST_PENALTY_EN (see lane_tracker): empty-lane presses become misses and break the combo.
module note_hit_judge
  import rb_pkg::*;
(
  input logic Clk,
  input logic Reset_n,
  note_hit_judge_if.slave bus
);
  lane_vec_t hit_v, miss_v;
  judge_evt_t evt;
  logic playing_q;
  logic [2:0] nh;
  logic [SCORE_W:0] score_sum;
  logic [SCORE_W-1:0] score_n;
  logic [8:0] combo_sum;
  logic [7:0] combo_n;
  logic [2:0] mult_n;
  int mult_raw;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_tracker u_lane (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .playing   (bus.playing),
      .tick      (bus.frame_tick),
      .enter_tap (bus.lane_enter[i]),
      .exit_tap  (bus.lane_exit[i]),
      .button    (bus.buttons[i]),
      .hit       (hit_v[i]),
      .miss      (miss_v[i])
    );
  end
  assign evt = {hit_v, miss_v};
  always_comb begin
    nh = '0;
    for (int i = 0; i < NUM_LANES; i++) nh = nh + 3'(evt.hit[i]);
  end
  // points use the multiplier in force before this cycle's combo update
  always_comb begin
    score_sum = {1'b0, bus.score} + (SCORE_W+1)'(int'(nh) * POINTS * int'(bus.multiplier));
    score_n = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_sum = {1'b0, bus.combo} + 9'(nh);
    combo_n = |evt.miss ? '0 : combo_sum[8] ? '1 : combo_sum[7:0];
    mult_raw = 1 + int'(combo_n) / COMBO_STEP;
    mult_n = 3'(mult_raw > MULT_MAX ? MULT_MAX : mult_raw);
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      playing_q <= 1'b0;
      bus.hit_pulse <= '0;
      bus.miss_pulse <= '0;
      bus.score <= '0;
      bus.combo <= '0;
      bus.multiplier <= 3'd1;
    end else begin
      playing_q <= bus.playing;
      bus.hit_pulse <= evt.hit;
      bus.miss_pulse <= evt.miss;
      if (bus.playing && !playing_q) begin
        bus.score <= '0;
        bus.combo <= '0;
        bus.multiplier <= 3'd1;
      end else if (bus.playing) begin
        bus.score <= score_n;
        bus.combo <= combo_n;
        bus.multiplier <= mult_n;
      end
    end
endmodule
